mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous memory port between the instruction-cache refill path and the data-cache/load-store path.
- Sits between both cache controllers and the memory array.
- Arbitrates round-robin, holds the address/write data for a fixed memory latency, captures the read data, and returns it with a one-cycle ready pulse to the granted requester only.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 38 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter and its round-robin helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  localparam int MEM_LAT_MAX = 7;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin decision with a last-grant register; on a tie the port
// that did not win last time is chosen.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req_i,
  input  logic  req_d,
  input  logic  update_en,
  output logic  any_req,
  output port_e winner
);

  port_e last_grant_q, last_grant_d;

  always_comb begin
    any_req = req_i | req_d;
    if (req_i && req_d) begin
      winner = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
    end else if (req_d) begin
      winner = PORT_D;
    end else begin
      winner = PORT_I;
    end
    last_grant_d = update_en ? winner : last_grant_q;
  end

  // Starts as DATA so the first tie after reset goes to the instruction side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the I-cache refill and D-cache
// paths: round-robin grant, fixed-latency access, one-cycle ready pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);
  localparam bit LAT_OK = (MEM_LAT >= 1) && (MEM_LAT <= MEM_LAT_MAX);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              txn_we_q, txn_we_d;

  logic  arb_update;
  logic  any_req;
  port_e winner;

  rr_arbiter2 u_rr (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .req_i     (i_req),
    .req_d     (d_req),
    .update_en (arb_update),
    .any_req   (any_req),
    .winner    (winner)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    i_data_d    = i_data_q;
    d_data_d    = d_data_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    cnt_d       = cnt_q;
    txn_we_d    = txn_we_q;
    arb_update  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = GNT_NONE;
        if (any_req) begin
          arb_update = 1'b1;
          cnt_d      = 3'd1;
          state_d    = ST_ACCESS;
          if (winner == PORT_D) begin
            grant_d     = GNT_D;
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
            txn_we_d    = d_we;
          end else begin
            grant_d     = GNT_I;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            txn_we_d    = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        // Capture and raise ready together so both appear in the RESP cycle.
        if (cnt_q == LAT_CNT) begin
          state_d = ST_RESP;
          if (grant_q == GNT_I) begin
            i_data_d  = mem_rdata;
            i_ready_d = 1'b1;
          end else begin
            if (!txn_we_q) d_data_d = mem_rdata;
            d_ready_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        grant_d     = GNT_NONE;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cnt_d       = 3'd0;
        txn_we_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      i_data_q    <= '0;
      d_data_q    <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      cnt_q       <= 3'd0;
      txn_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      i_data_q    <= i_data_d;
      d_data_q    <= d_data_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      cnt_q       <= cnt_d;
      txn_we_q    <= txn_we_d;
    end
  end

  assign grant     = grant_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_data_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

  a_mem_lat_range : assert property (@(posedge iCLK) LAT_OK)
    else $error("mem_port_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MEM_LAT_MAX);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters with MEM_LAT = 1, 2, 3 share clock and reset;
// each scenario drives one instance and checks hand-computed cycle values.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic        i_req     [3];
  logic [7:0]  i_addr    [3];
  logic [31:0] i_data    [3];
  logic        i_ready   [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [7:0]  d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic [31:0] d_rdata   [3];
  logic        d_ready   [3];
  logic [7:0]  mem_addr  [3];
  logic        mem_we    [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [1:0]  grant     [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
      .iCLK      (clk),
      .iRST_n    (rst_n),
      .i_req     (i_req[g]),
      .i_addr    (i_addr[g]),
      .i_data    (i_data[g]),
      .i_ready   (i_ready[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_rdata   (d_rdata[g]),
      .d_ready   (d_ready[g]),
      .mem_addr  (mem_addr[g]),
      .mem_we    (mem_we[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .grant     (grant[g])
    );
  end

  task automatic applyStimulus(input int idx, input logic ireq, input logic [7:0] iaddr,
                               input logic dreq, input logic dwe, input logic [7:0] daddr,
                               input logic [31:0] dwdata, input logic [31:0] rdata);
    i_req[idx]     = ireq;
    i_addr[idx]    = iaddr;
    d_req[idx]     = dreq;
    d_we[idx]      = dwe;
    d_addr[idx]    = daddr;
    d_wdata[idx]   = dwdata;
    mem_rdata[idx] = rdata;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    rst_n = 1'b0;
    #2;
    checkOutput("rst grant",   32'(grant[0]),   32'h0);
    checkOutput("rst mem_we",  32'(mem_we[0]),  32'h0);
    checkOutput("rst i_ready", 32'(i_ready[0]), 32'h0);
    checkOutput("rst i_data",  i_data[0],       32'h0);
    checkOutput("rst d_rdata", d_rdata[0],      32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] instruction read, MEM_LAT=1");
    applyStimulus(0, 1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0, 32'h00500093);
    step(1);
    checkOutput("t1 grant",    32'(grant[0]),    32'h1);
    checkOutput("t1 mem_addr", 32'(mem_addr[0]), 32'h04);
    checkOutput("t1 mem_we",   32'(mem_we[0]),   32'h0);
    checkOutput("t1 early rdy",32'(i_ready[0]),  32'h0);
    step(1);
    checkOutput("t1 i_ready",  32'(i_ready[0]),  32'h1);
    checkOutput("t1 i_data",   i_data[0],        32'h00500093);
    checkOutput("t1 d_ready",  32'(d_ready[0]),  32'h0);
    i_req[0] = 1'b0;
    step(1);
    checkOutput("t1 idle grant", 32'(grant[0]),   32'h0);
    checkOutput("t1 rdy drop",   32'(i_ready[0]), 32'h0);
    checkOutput("t1 addr clr",   32'(mem_addr[0]),32'h0);

    $display("[TB] data write, MEM_LAT=1");
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'hBADBAD00);
    step(1);
    checkOutput("t2 grant",     32'(grant[0]),    32'h2);
    checkOutput("t2 mem_we",    32'(mem_we[0]),   32'h1);
    checkOutput("t2 mem_addr",  32'(mem_addr[0]), 32'h10);
    checkOutput("t2 mem_wdata", mem_wdata[0],     32'hDEADBEEF);
    step(1);
    checkOutput("t2 we drop",   32'(mem_we[0]),   32'h0);
    checkOutput("t2 d_ready",   32'(d_ready[0]),  32'h1);
    checkOutput("t2 i_ready",   32'(i_ready[0]),  32'h0);
    checkOutput("t2 d_rdata",   d_rdata[0],       32'h0);
    d_req[0] = 1'b0;
    step(1);
    checkOutput("t2 idle grant", 32'(grant[0]),   32'h0);
    checkOutput("t2 rdy drop",   32'(d_ready[0]), 32'h0);

    $display("[TB] instruction request dropped after grant");
    applyStimulus(0, 1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0, 32'h13572468);
    step(1);
    checkOutput("t4 grant", 32'(grant[0]), 32'h1);
    i_req[0]  = 1'b0;
    i_addr[0] = 8'hFF;
    step(1);
    checkOutput("t4 i_ready",  32'(i_ready[0]),  32'h1);
    checkOutput("t4 i_data",   i_data[0],        32'h13572468);
    checkOutput("t4 addr hold",32'(mem_addr[0]), 32'h08);
    step(1);
    checkOutput("t4 idle grant", 32'(grant[0]),   32'h0);
    checkOutput("t4 rdy drop",   32'(i_ready[0]), 32'h0);

    $display("[TB] reset during data write access");
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 32'h0F0F0F0F, 32'h0);
    step(1);
    checkOutput("t5 mem_we pre", 32'(mem_we[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 rst mem_we",  32'(mem_we[0]),   32'h0);
    checkOutput("t5 rst grant",   32'(grant[0]),    32'h0);
    checkOutput("t5 rst mem_addr",32'(mem_addr[0]), 32'h0);
    checkOutput("t5 rst i_data",  i_data[0],        32'h0);
    d_req[0] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("t5 no d_ready", 32'(d_ready[0]), 32'h0);
    applyStimulus(0, 1'b1, 8'h30, 1'b1, 1'b0, 8'h31, 32'h0, 32'h55AA55AA);
    step(1);
    checkOutput("t5 tie grant", 32'(grant[0]),    32'h1);
    checkOutput("t5 tie addr",  32'(mem_addr[0]), 32'h30);
    step(1);
    checkOutput("t5 i_ready",   32'(i_ready[0]),  32'h1);
    checkOutput("t5 d_ready lo",32'(d_ready[0]),  32'h0);
    i_req[0] = 1'b0;
    step(2);
    checkOutput("t5 wait grant", 32'(grant[0]),    32'h2);
    checkOutput("t5 wait addr",  32'(mem_addr[0]), 32'h31);
    step(1);
    checkOutput("t5 d_ready",    32'(d_ready[0]),  32'h1);
    checkOutput("t5 d_rdata",    d_rdata[0],       32'h55AA55AA);
    d_req[0] = 1'b0;
    step(1);

    $display("[TB] both requests held, MEM_LAT=2");
    applyStimulus(1, 1'b1, 8'h40, 1'b1, 1'b0, 8'h41, 32'h0, 32'h24681357);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = k[0] ? 2'b10 : 2'b01;
      step(1);
      checkOutput($sformatf("t3 grant k%0d", k), 32'(grant[1]), 32'(exp_g));
      step(2);
      checkOutput($sformatf("t3 resp grant k%0d", k), 32'(grant[1]), 32'(exp_g));
      checkOutput($sformatf("t3 i_ready k%0d", k), 32'(i_ready[1]), 32'(!k[0]));
      checkOutput($sformatf("t3 d_ready k%0d", k), 32'(d_ready[1]), 32'(k[0]));
      step(1);
      checkOutput($sformatf("t3 idle k%0d", k), 32'(grant[1]), 32'h0);
    end
    i_req[1] = 1'b0;
    d_req[1] = 1'b0;
    checkOutput("t3 i_data", i_data[1],  32'h24681357);
    checkOutput("t3 d_rdata", d_rdata[1], 32'h24681357);

    $display("[TB] two data reads, MEM_LAT=3");
    applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0, 32'hCAFEF00D);
    step(1);
    checkOutput("t6 grant", 32'(grant[2]), 32'h2);
    step(2);
    checkOutput("t6 early rdy",  32'(d_ready[2]), 32'h0);
    checkOutput("t6 early data", d_rdata[2],      32'h0);
    step(1);
    checkOutput("t6 d_ready1", 32'(d_ready[2]), 32'h1);
    checkOutput("t6 d_rdata1", d_rdata[2],      32'hCAFEF00D);
    d_req[2] = 1'b0;
    step(1);
    checkOutput("t6 idle", 32'(grant[2]), 32'h0);
    applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 32'h0, 32'h12345678);
    step(3);
    checkOutput("t6 hold rdy",  32'(d_ready[2]), 32'h0);
    checkOutput("t6 hold data", d_rdata[2],      32'hCAFEF00D);
    step(1);
    checkOutput("t6 d_ready2", 32'(d_ready[2]), 32'h1);
    checkOutput("t6 d_rdata2", d_rdata[2],      32'h12345678);
    d_req[2] = 1'b0;
    step(1);
    checkOutput("t6 rdy drop",  32'(d_ready[2]), 32'h0);
    checkOutput("t6 data keep", d_rdata[2],      32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
